// File: rtl/rr_grant_fsm.sv
// Round-robin grant FSM: one registered one-hot grant at a time, fair rotation,
// and optional forced rotation after MAX_HOLD cycles when other requesters wait.
module rr_grant_fsm #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       preempt
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TEN_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [TEN_W-1:0] TEN_MAX    = TEN_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               preempt_q, preempt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [TEN_W-1:0]   tenure_q, tenure_d;

    logic [ID_W-1:0]    sel;
    logic               found;
    int                 idx;
    logic               owner_req;
    logic               others_req;

    // First active requester at or above ptr, wrapping from the top index back to 0.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    assign owner_req  = req[gnt_id_q];
    assign others_req = |(req & ~gnt_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        preempt_d   = 1'b0;
        ptr_d       = ptr_q;
        tenure_d    = tenure_q;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (found) begin
                    gnt_d[sel]  = 1'b1;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = sel;
                    tenure_d    = TEN_W'(1);
                    ptr_d       = (sel == LAST_ID) ? '0 : sel + 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Release is checked first so a dropping owner never reports preempt.
                if (!owner_req) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (PREEMPT_EN && tenure_q == TEN_MAX && others_req) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    preempt_d   = 1'b1;
                    state_d     = IDLE;
                end else if (PREEMPT_EN && tenure_q != TEN_MAX) begin
                    tenure_d = tenure_q + 1'b1;
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            preempt_q   <= 1'b0;
            ptr_q       <= '0;
            tenure_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            preempt_q   <= preempt_d;
            ptr_q       <= ptr_d;
            tenure_q    <= tenure_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;

endmodule

// File: doc/rr_grant_fsm.md
# rr_grant_fsm

Parametrised round-robin grant state machine for NUM_REQ requesters. It hands out one registered one-hot grant at a time and rotates priority fairly. Optionally, it revokes a grant after MAX_HOLD cycles when other requesters are waiting. It replaces fixed two-channel, fixed-priority grant FSMs in the bus/resource-sharing layer, sitting between requesting agents and a single shared resource.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..32
- MAX_HOLD, 8, maximum grant tenure in cycles before forced rotation when contended; 0 disables preemption
- ID_W, $clog2(NUM_REQ), width of gnt_id (derived; not overridden)

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  NUM_REQ  level request per requester; held high for as long as the resource is wanted
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when no owner
- gnt_valid  output  1  registered; high iff gnt is non-zero
- gnt_id  output  ID_W  registered binary index of current owner; holds last owner when gnt_valid=0
- preempt  output  1  registered one-cycle pulse, coincident with the cycle the grant drops due to MAX_HOLD expiry

## Operation
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, preempt=0, state=IDLE, ptr=0, tenure=0.
- State IDLE:
  - If req is non-zero, select the first requester at or above ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - On that edge: gnt=onehot(sel), gnt_id=sel, gnt_valid=1, tenure=1, ptr=(sel+1) mod NUM_REQ, state→GRANT.
  - If req is zero, remain in IDLE with outputs zero.
- State GRANT, evaluated each edge with owner=gnt_id:
  - **Release:** req[owner]=0 → gnt=0, gnt_valid=0, state→IDLE, preempt=0.
  - **Preempt:** MAX_HOLD≠0, tenure==MAX_HOLD, req[owner]=1, and any other req bit set → gnt=0, gnt_valid=0, preempt=1, state→IDLE.
  - **Hold:** otherwise keep gnt unchanged; tenure=min(tenure+1, MAX_HOLD) (saturating).
  - Release takes precedence over preempt when both apply on the same edge (preempt stays 0).
- preempt is 0 on every edge other than a preempt edge.
- Illegal state encodings → state=IDLE, gnt=0, gnt_valid=0.
- ptr only changes on a grant edge. Consequence: a preempted owner that keeps requesting is served again only after every other active requester.
- Requests that rise and fall while another requester owns the resource are not remembered (level-sensitive, no queuing).
- gnt is always one-hot or zero; gnt_valid == |gnt at all times.

## Timing
- Grant latency from IDLE: req sampled at edge k → gnt high after edge k (1 cycle after req first visible).
- Release latency: req[owner] low before edge k → gnt low after edge k.
- Mandatory one-cycle gap (gnt=0) between consecutive grants, including owner-to-owner handoff and preemption.
- With MAX_HOLD=M>0 under contention, gnt is high for exactly M cycles; preempt pulses high in the first gap cycle.
- Uncontended owner: tenure saturates at M; the grant holds indefinitely. Once another req appears before edge k, the grant drops at edge k.
- Asynchronous reset mid-grant: all outputs go to zero immediately, without waiting for a clock edge. The first grant after deassertion searches from ptr=0.

## Test plan
- **Reset/idle:** reset high with req=4'b1111 → gnt=0, gnt_valid=0, preempt=0. Release reset, req=4'b1111 → one edge later gnt=4'b0001, gnt_id=0.
- **Round-robin (NUM_REQ=4, MAX_HOLD=0):** req=4'b1111; drop each owner's req for one cycle after 3 grant cycles → owner order 0,1,2,3,0, with a one-cycle gnt=0 gap between each.
- **Wrap search:** ptr=3 (after granting 2), req=4'b0011 → next grant is 4'b0001; ptr becomes 1.
- **Preemption (MAX_HOLD=4):**
  - req[1] held high; req[3] asserted on the 2nd grant cycle → gnt=4'b0010 for exactly 4 cycles.
  - Then gnt=0 with preempt=1 for 1 cycle, then gnt=4'b1000.
- **Uncontended saturation and priority (MAX_HOLD=4):**
  - Only req[2] high for 20 cycles → gnt=4'b0100 for all 20 cycles, preempt never asserted.
  - Assert req[0] → gnt drops at the next edge with preempt=1.
  - On a separate edge where req[owner] falls while tenure==MAX_HOLD and others are waiting → release only, preempt=0.
- **Async reset mid-grant:** reset pulses between clock edges while gnt=4'b0100 → gnt=0 before the next edge. After reset, with req=4'b0110 → gnt=4'b0010.
